// File: rtl/banco_registradores_scoreboard.sv
// Register file with a per-register pending-write scoreboard.
// Reads are combinational with write-back forwarding. Issue stalls while a
// source register still has an outstanding write, or while the destination's
// pending counter is saturated. Write-back retires pending writes and commits
// data into the array.
module banco_registradores_scoreboard #(
  parameter int LARGURA  = 32,
  parameter int NUM_REGS = 32,
  parameter int END      = 5,
  parameter int MAX_PEND = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               emite_valido,
  input  logic               emite_escreve,
  input  logic [END-1:0]     emite_destino,
  input  logic [END-1:0]     leitura_rs,
  input  logic [END-1:0]     leitura_rt,
  output logic [LARGURA-1:0] dado_rs,
  output logic [LARGURA-1:0] dado_rt,
  output logic               stall,
  input  logic               wb_valido,
  input  logic [END-1:0]     wb_destino,
  input  logic [LARGURA-1:0] wb_dado,
  output logic [END:0]       em_voo,
  output logic               erro
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0]  PEND_UM  = PW'(1);
  localparam logic [PW-1:0]  PEND_MAX = PW'(MAX_PEND);
  localparam logic [END:0]   VOO_UM   = (END+1)'(1);

  logic [LARGURA-1:0] regs [NUM_REGS];
  logic [PW-1:0]      pend [NUM_REGS];

  logic [PW-1:0] pend_rs;
  logic [PW-1:0] pend_rt;
  logic [PW-1:0] pend_wb;
  logic [PW-1:0] ef_rs;
  logic [PW-1:0] ef_rt;
  logic          destino_cheio;
  logic          aceita;
  logic          inc;
  logic          dec;
  logic          wb_orfao;

  // Source reads: register 0 is zero, a same-cycle write-back is forwarded
  always_comb begin
    dado_rs = regs[leitura_rs];
    if (leitura_rs == '0)
      dado_rs = '0;
    else if (wb_valido && (wb_destino == leitura_rs))
      dado_rs = wb_dado;
  end

  // Same forwarding logic for the rt port
  always_comb begin
    dado_rt = regs[leitura_rt];
    if (leitura_rt == '0)
      dado_rt = '0;
    else if (wb_valido && (wb_destino == leitura_rt))
      dado_rt = wb_dado;
  end

  // Effective pending counts discount a write-back retiring this cycle, so a
  // consumer can issue in the same cycle its producer writes back
  always_comb begin
    pend_rs = pend[leitura_rs];
    pend_rt = pend[leitura_rt];
    pend_wb = pend[wb_destino];
    ef_rs = pend_rs - PW'(wb_valido && (wb_destino == leitura_rs) && (pend_rs != '0));
    ef_rt = pend_rt - PW'(wb_valido && (wb_destino == leitura_rt) && (pend_rt != '0));
    destino_cheio = (pend[emite_destino] == PEND_MAX) &&
                    !(wb_valido && (wb_destino == emite_destino));
    stall = emite_valido &&
            (((leitura_rs != '0) && (ef_rs != '0)) ||
             ((leitura_rt != '0) && (ef_rt != '0)) ||
             (emite_escreve && (emite_destino != '0) && destino_cheio));
    aceita   = emite_valido && !stall;
    inc      = aceita && emite_escreve && (emite_destino != '0);
    dec      = wb_valido && (wb_destino != '0) && (pend_wb != '0);
    wb_orfao = wb_valido && (wb_destino != '0) && (pend_wb == '0);
  end

  // Register array: write-back commits data, register 0 is never written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else if (wb_valido && (wb_destino != '0)) begin
      regs[wb_destino] <= wb_dado;
    end
  end

  // Pending counters: an issue and a retire on the same register cancel out
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        pend[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc && (emite_destino == END'(r)) && !(dec && (wb_destino == END'(r))))
          pend[r] <= pend[r] + PEND_UM;
        else if (dec && (wb_destino == END'(r)) && !(inc && (emite_destino == END'(r))))
          pend[r] <= pend[r] - PEND_UM;
      end
    end
  end

  // Running total of outstanding writes, tracking the same +1/-1 events
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      em_voo <= '0;
    else if (inc && !dec)
      em_voo <= em_voo + VOO_UM;
    else if (dec && !inc)
      em_voo <= em_voo - VOO_UM;
  end

  // Sticky flag for a write-back that had no matching pending write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      erro <= 1'b0;
    else if (wb_orfao)
      erro <= 1'b1;
  end

endmodule
